// File: rtl/kb_row_scan.sv
// 4x4 keypad row driver with debounced key capture (SCAN -> DEBOUNCE -> HELD).
// Define KB_REPEAT_EN to make a held key strobe key_valid every REPEAT_SCANS samples.
module kb_row_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_SCANS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] K_COL,
  output logic [3:0] K_ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       r_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       cand_reg;
  logic [3:0]       row_reg;
  logic [3:0]       code_reg;
  logic             valid_reg;
  logic             held_reg;

  logic             sample;
  logic             hit;
  logic [1:0]       col;
  logic [3:0]       code;
  logic [1:0]       r_inc;
  logic [3:0]       row_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             release_done;
  logic             rep_fire;

  assign sample  = (div_reg == DIV_LAST);
  assign r_inc   = r_reg + 2'd1;
  assign cnt_inc = cnt_reg + CNT_W'(1);
  assign code    = {r_reg, col};
  assign release_done = K_COL[cand_reg[1:0]] && (cnt_inc == CNT_DONE);

  // Active-low drive pattern for the row after r_reg
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_inc[gi] = (r_inc != 2'(gi));
  end

  // Lowest-index low column wins
  always_comb begin
    hit = 1'b0;
    col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!K_COL[i]) begin
        hit = 1'b1;
        col = 2'(i);
      end
    end
  end

`ifdef KB_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_reg;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc  = rep_reg + REP_W'(1);
  assign rep_fire = sample && (state_reg == HELD) && (rep_inc == REP_DONE);

  // Restarts on every entry to HELD because it is cleared in all other states
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != HELD) begin
      rep_reg <= '0;
    end else if (sample) begin
      rep_reg <= (rep_inc == REP_DONE) ? '0 : rep_inc;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= SCAN;
      div_reg   <= '0;
      r_reg     <= 2'd0;
      cnt_reg   <= '0;
      cand_reg  <= 4'h0;
      row_reg   <= 4'b1110;
      code_reg  <= 4'h0;
      valid_reg <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      div_reg   <= sample ? '0 : div_reg + DIV_W'(1);
      if (sample) begin
        unique case (state_reg)
          SCAN: begin
            if (!hit) begin
              r_reg   <= r_inc;
              row_reg <= row_inc;
            end else if (DEBOUNCE_CNT == 1) begin
              cand_reg  <= code;
              code_reg  <= code;
              valid_reg <= 1'b1;
              held_reg  <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= HELD;
            end else begin
              cand_reg  <= code;
              cnt_reg   <= CNT_W'(1);
              state_reg <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (hit && code == cand_reg) begin
              if (cnt_inc == CNT_DONE) begin
                code_reg  <= cand_reg;
                valid_reg <= 1'b1;
                held_reg  <= 1'b1;
                cnt_reg   <= '0;
                state_reg <= HELD;
              end else begin
                cnt_reg <= cnt_inc;
              end
            end else begin
              cnt_reg   <= '0;
              r_reg     <= r_inc;
              row_reg   <= row_inc;
              state_reg <= SCAN;
            end
          end
          HELD: begin
            if (release_done) begin
              held_reg  <= 1'b0;
              cnt_reg   <= '0;
              r_reg     <= r_inc;
              row_reg   <= row_inc;
              state_reg <= SCAN;
            end else begin
              // Any pressed sample restarts the release count
              cnt_reg <= K_COL[cand_reg[1:0]] ? cnt_inc : '0;
              if (rep_fire) valid_reg <= 1'b1;
            end
          end
          default: state_reg <= SCAN;
        endcase
      end
    end
  end

  assign K_ROW     = row_reg;
  assign key_code  = code_reg;
  assign key_valid = valid_reg;
  assign key_held  = held_reg;
endmodule
